// File: rtl/io_core_pkg.sv
// Shared constants for the probe I/O core: register offsets and bus width.
package io_core_pkg;
  localparam int BUS_W       = 16;
  localparam int STROBE_OFS  = 0;
  localparam int COUNT_OFS   = 1;
  localparam int IN_BASE_OFS = 2;
endpackage

// File: rtl/probe_io_core.sv
// Bus-attached probe core: snoops a pass-through bus, owns a small register window,
// and atomically captures input probes / updates output probes on a strobe write.
module probe_io_core
  import io_core_pkg::*;
#(
  parameter int BASE_ADDR = 0,
  parameter int N_IN      = 4,
  parameter int IN_W      = 8,
  parameter int N_OUT     = 4,
  parameter int OUT_W     = 8,
  parameter logic [OUT_W-1:0] OUT_INIT = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*IN_W-1:0]   probe_in,
  output logic [N_OUT*OUT_W-1:0] probe_out,
  input  logic [BUS_W-1:0]       addr_i,
  input  logic [BUS_W-1:0]       wdata_i,
  input  logic [BUS_W-1:0]       rdata_i,
  input  logic                   rw_i,
  input  logic                   valid_i,
  output logic [BUS_W-1:0]       addr_o,
  output logic [BUS_W-1:0]       wdata_o,
  output logic [BUS_W-1:0]       rdata_o,
  output logic                   rw_o,
  output logic                   valid_o
);

  localparam int LAST         = 1 + N_IN + N_OUT;
  localparam int OUT_BASE_OFS = IN_BASE_OFS + N_IN;
  localparam logic [16:0] BASE17 = 17'(BASE_ADDR);
  localparam logic [16:0] LAST17 = 17'(BASE_ADDR + LAST);

  if (N_IN < 1 || N_IN > 16 || IN_W < 1 || IN_W > 16 ||
      N_OUT < 1 || N_OUT > 16 || OUT_W < 1 || OUT_W > 16 ||
      BASE_ADDR < 0 || BASE_ADDR + LAST > 65535) begin : g_param_check
    $fatal(1, "probe_io_core: parameter out of legal range");
  end

  logic [16:0]      addr17, ofs;
  logic             owned, rd_hit, wr_hit, strobe;
  logic [BUS_W-1:0] count, rd_val;
  logic [IN_W-1:0]  in_buf  [N_IN];
  logic [OUT_W-1:0] out_buf [N_OUT];

  // 17-bit compare keeps the window check safe near the top of the address space
  assign addr17 = {1'b0, addr_i};
  assign ofs    = addr17 - BASE17;
  assign owned  = valid_i && (addr17 >= BASE17) && (addr17 <= LAST17);
  assign rd_hit = owned && !rw_i;
  assign wr_hit = owned && rw_i;
  assign strobe = wr_hit && (ofs == 17'(STROBE_OFS)) && wdata_i[0];

  always_ff @(posedge clk) begin
    if (rst)         count <= '0;
    else if (strobe) count <= count + 16'd1;
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_in
    logic [IN_W-1:0] cap_q;
    always_ff @(posedge clk) begin
      if (rst)         cap_q <= '0;
      else if (strobe) cap_q <= probe_in[k*IN_W +: IN_W];
    end
    assign in_buf[k] = cap_q;
  end

  // Output buffers stage writes; probes only move together on a strobe
  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    logic [OUT_W-1:0] buf_q, probe_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        buf_q   <= OUT_INIT;
        probe_q <= OUT_INIT;
      end else begin
        if (wr_hit && ofs == 17'(OUT_BASE_OFS + k)) buf_q <= wdata_i[OUT_W-1:0];
        if (strobe) probe_q <= buf_q;
      end
    end
    assign out_buf[k] = buf_q;
    assign probe_out[k*OUT_W +: OUT_W] = probe_q;
  end

  always_comb begin
    rd_val = '0;
    if (ofs == 17'(COUNT_OFS)) rd_val = count;
    for (int k = 0; k < N_IN; k++)
      if (ofs == 17'(IN_BASE_OFS + k)) rd_val = 16'(in_buf[k]);
    for (int k = 0; k < N_OUT; k++)
      if (ofs == 17'(OUT_BASE_OFS + k)) rd_val = 16'(out_buf[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_o  <= '0;
      wdata_o <= '0;
      rdata_o <= '0;
      rw_o    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      addr_o  <= addr_i;
      wdata_o <= wdata_i;
      rdata_o <= rd_hit ? rd_val : rdata_i;
      rw_o    <= rw_i;
      valid_o <= valid_i;
    end
  end

endmodule
